// File: rtl/board_row_store_if.sv
// Row request/response bus of the board row store.
// The master drives requests; the slave (the store) returns one response pulse per request.
interface board_row_store_if #(
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [ROW_W-1:0]  req_wdata;
    logic              rsp_valid;
    logic [ROW_W-1:0]  rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/board_row_store.sv
// Row-organised playfield store: single-cycle row read/write, multi-cycle
// line-clear shift and full-board clear jobs, and a per-row "row full" mask.
module board_row_store #(
    parameter int ROWS   = 30,
    parameter int ROW_W  = 32,
    parameter int ADDR_W = 11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    board_row_store_if.slave     bus,
    input  logic                 clr_line_start,
    input  logic [5:0]           clr_line_row,
    input  logic                 clear_all_start,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS-1:0]      full_row_mask
);
    localparam int IDX_W = $clog2(ROWS);
    localparam int CELLS = ROW_W / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CLRALL,
        S_FIN
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [ROW_W-1:0]   r_rows [ROWS];
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [ROW_W-1:0]   r_rsp_rdata;

    logic               w_accept;
    logic               w_addr_ok;
    logic [IDX_W-1:0]   w_idx;
    logic               w_line_ok;
    logic [ROWS-1:0]    w_full_mask;

    // Requests are only taken while idle and no job is being started this cycle.
    assign bus.req_ready = (r_state == S_IDLE) & ~clr_line_start & ~clear_all_start;
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_addr_ok     = bus.req_addr < ADDR_W'(ROWS);
    assign w_idx         = bus.req_addr[IDX_W-1:0];
    assign w_line_ok     = clr_line_row < 6'(ROWS);

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_FIN);
    assign full_row_mask = w_full_mask;

    // Job FSM, row storage and the registered request response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_rows[i] <= '0;
            end
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_err <= ~w_addr_ok;
                if (!w_addr_ok) begin
                    r_rsp_rdata <= '0;
                end else if (bus.req_we) begin
                    r_rsp_rdata    <= bus.req_wdata;
                    r_rows[w_idx]  <= bus.req_wdata;
                end else begin
                    r_rsp_rdata <= r_rows[w_idx];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (clear_all_start) begin
                        r_state <= S_CLRALL;
                        r_ptr   <= '0;
                    end else if (clr_line_start) begin
                        if (w_line_ok) begin
                            r_state <= S_SHIFT;
                            r_ptr   <= clr_line_row[IDX_W-1:0];
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_SHIFT: begin
                    // Walk upward: each row takes the one above it, top row empties last.
                    if (r_ptr != '0) begin
                        r_rows[r_ptr] <= r_rows[r_ptr - IDX_W'(1)];
                        r_ptr         <= r_ptr - IDX_W'(1);
                    end else begin
                        r_rows[0] <= '0;
                        r_state   <= S_FIN;
                    end
                end
                S_CLRALL: begin
                    r_rows[r_ptr] <= '0;
                    if (r_ptr == IDX_W'(ROWS - 1)) begin
                        r_state <= S_FIN;
                    end else begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A row is full when none of its 2-bit cells is empty.
    always_comb begin
        w_full_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_full_mask[r] = 1'b1;
            for (int c = 0; c < CELLS; c++) begin
                if (r_rows[r][2*c +: 2] == 2'b00) begin
                    w_full_mask[r] = 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_board_row_store.sv
// Directed bench for board_row_store with a row-array reference model and a
// per-cycle compare process on the response and full-row mask.
module tb_board_row_store;
    localparam int ROWS   = 30;
    localparam int ROW_W  = 32;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clr_line_start;
    logic [5:0]        clr_line_row;
    logic              clear_all_start;
    logic              busy;
    logic              done;
    logic [ROWS-1:0]   full_row_mask;

    board_row_store_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bif ();

    board_row_store #(.ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bif),
        .clr_line_start  (clr_line_start),
        .clr_line_row    (clr_line_row),
        .clear_all_start (clear_all_start),
        .busy            (busy),
        .done            (done),
        .full_row_mask   (full_row_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the board as an array of rows, plus the one expected response.
    logic [ROW_W-1:0] m_rows [ROWS];
    logic             exp_vld = 1'b0;
    logic [ROW_W-1:0] exp_rd  = '0;
    logic             exp_err = 1'b0;
    logic             run     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [ROWS-1:0] model_mask();
        logic [ROWS-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            m[r] = 1'b1;
            for (int c = 0; c < ROW_W / 2; c++) begin
                if (((m_rows[r] >> (2 * c)) & 32'h3) == 32'h0) m[r] = 1'b0;
            end
        end
        return m;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
    endtask

    // Compare process: response every cycle, mask whenever no job is running.
    always @(negedge clk) begin
        if (run && reset_n) begin
            check("rsp_valid", 64'(bif.rsp_valid), 64'(exp_vld));
            if (exp_vld && bif.rsp_valid) begin
                check("rsp_rdata", 64'(bif.rsp_rdata), 64'(exp_rd));
                check("rsp_err", 64'(bif.rsp_err), 64'(exp_err));
            end
            exp_vld = 1'b0;
            if (!busy) check("full_row_mask", 64'(full_row_mask), 64'(model_mask()));
        end
    end

    task automatic do_req(input logic we, input int addr, input logic [ROW_W-1:0] data,
                          output logic [ROW_W-1:0] rd, output logic err);
        @(posedge clk); #1;
        check("req_ready_idle", 64'(bif.req_ready), 64'd1);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = ADDR_W'(addr);
        bif.req_wdata = data;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        if (addr < ROWS) begin
            exp_rd  = we ? data : m_rows[addr];
            exp_err = 1'b0;
            if (we) m_rows[addr] = data;
        end else begin
            exp_rd  = '0;
            exp_err = 1'b1;
        end
        exp_vld = 1'b1;
        @(negedge clk);
        rd  = bif.rsp_rdata;
        err = bif.rsp_err;
    endtask

    task automatic start_job(input logic line, input logic [5:0] row, input logic all);
        @(posedge clk); #1;
        clr_line_start  = line;
        clr_line_row    = row;
        clear_all_start = all;
        @(posedge clk); #1;
        clr_line_start  = 1'b0;
        clear_all_start = 1'b0;
        if (all) begin
            model_clear();
        end else if (line && row < ROWS) begin
            for (int k = int'(row); k > 0; k--) m_rows[k] = m_rows[k-1];
            m_rows[0] = '0;
        end
    endtask

    task automatic wait_job(input int exp_busy, input string name);
        int n;
        int d;
        n = 0;
        d = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (done) d++;
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        check({name, "_done_pulses"}, 64'(d), 64'd1);
    endtask

    logic [ROW_W-1:0] rd;
    logic             err;

    initial begin
        reset_n         = 1'b0;
        clr_line_start  = 1'b0;
        clr_line_row    = '0;
        clear_all_start = 1'b0;
        bif.req_valid   = 1'b0;
        bif.req_we      = 1'b0;
        bif.req_addr    = '0;
        bif.req_wdata   = '0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(bif.rsp_err), 64'd0);
        check("rst_mask", 64'(full_row_mask), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_req_ready", 64'(bif.req_ready), 64'd1);
        run = 1'b1;

        // 1: full row write/read
        do_req(1'b1, 5, 32'h5555_5555, rd, err);
        do_req(1'b0, 5, '0, rd, err);
        check("t1_read_row5", 64'(rd), 64'h5555_5555);
        check("t1_mask5", 64'(full_row_mask[5]), 64'd1);

        // 2: row with one empty cell, out-of-range read
        do_req(1'b1, 7, 32'hFFFF_FFFC, rd, err);
        check("t2_mask7", 64'(full_row_mask[7]), 64'd0);
        do_req(1'b0, 30, '0, rd, err);
        check("t2_oor_err", 64'(err), 64'd1);
        check("t2_oor_rdata", 64'(rd), 64'd0);
        do_req(1'b1, 2047, 32'hFFFF_FFFF, rd, err);
        check("t2_oor_write_err", 64'(err), 64'd1);

        // 3: line clear of row 3
        for (int r = 0; r < 4; r++) do_req(1'b1, r, 32'(r + 1), rd, err);
        start_job(1'b1, 6'd3, 1'b0);
        wait_job(5, "t3_line3");
        for (int r = 0; r < 4; r++) begin
            do_req(1'b0, r, '0, rd, err);
            check("t3_row_after_shift", 64'(rd), 64'(r));
        end
        do_req(1'b0, 5, '0, rd, err);
        check("t3_row5_kept", 64'(rd), 64'h5555_5555);

        // Line-clear boundaries: top row and a row past the board
        start_job(1'b1, 6'd0, 1'b0);
        wait_job(2, "line0");
        start_job(1'b1, 6'd40, 1'b0);
        wait_job(1, "line_oor");
        do_req(1'b0, 1, '0, rd, err);
        check("line_oor_row1", 64'(rd), 64'd1);

        // 4: full clear over random contents
        for (int r = 0; r < ROWS; r++) do_req(1'b1, r, $urandom, rd, err);
        do_req(1'b1, 10, 32'hAAAA_AAAA, rd, err);
        check("t4_mask10_pre", 64'(full_row_mask[10]), 64'd1);
        start_job(1'b0, 6'd0, 1'b1);
        wait_job(ROWS + 1, "t4_clrall");
        check("t4_mask_zero", 64'(full_row_mask), 64'd0);
        for (int r = 0; r < ROWS; r++) begin
            do_req(1'b0, r, '0, rd, err);
            check("t4_row_zero", 64'(rd), 64'd0);
        end

        // 5: both starts at once, then stray start and request while busy
        do_req(1'b1, 2, 32'hFFFF_FFFF, rd, err);
        do_req(1'b1, 9, 32'h5555_5555, rd, err);
        start_job(1'b1, 6'd1, 1'b1);
        @(negedge clk);
        clr_line_start = 1'b1;
        clr_line_row   = 6'd1;
        bif.req_valid  = 1'b1;
        bif.req_we     = 1'b1;
        bif.req_addr   = 11'd2;
        bif.req_wdata  = 32'h1234_5678;
        #1;
        check("t5_ready_busy", 64'(bif.req_ready), 64'd0);
        @(negedge clk);
        clr_line_start = 1'b0;
        bif.req_valid  = 1'b0;
        wait_job(ROWS - 1, "t5_clrall");
        repeat (3) begin
            @(negedge clk);
            check("t5_not_queued", 64'(busy), 64'd0);
        end
        do_req(1'b0, 2, '0, rd, err);
        check("t5_row2_zero", 64'(rd), 64'd0);
        do_req(1'b0, 9, '0, rd, err);
        check("t5_row9_zero", 64'(rd), 64'd0);

        // 6: reset in the middle of a shift
        do_req(1'b1, 0, 32'h5555_5555, rd, err);
        do_req(1'b1, 20, 32'hFFFF_FFFF, rd, err);
        start_job(1'b1, 6'd20, 1'b0);
        repeat (3) @(negedge clk);
        run     = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_mask", 64'(full_row_mask), 64'd0);
        check("t6_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        model_clear();
        exp_vld = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t6_req_ready", 64'(bif.req_ready), 64'd1);
        run = 1'b1;
        do_req(1'b0, 0, '0, rd, err);
        check("t6_row0", 64'(rd), 64'd0);
        do_req(1'b0, 20, '0, rd, err);
        check("t6_row20", 64'(rd), 64'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
